// File: rtl/histogram_ram_scheduler.sv
// Histogram RAM scheduler: queues bin increments for saturating read-modify-write,
// arbitrating the single-port RAM with host reads and a full-histogram clear sweep.
module histogram_ram_scheduler #(
  parameter int AW         = 8,
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          add_strobe,
  input  logic [AW-1:0] add_addr,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          clear_req,
  output logic          busy,
  output logic          drop_flag,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, A_RD, A_WAIT, A_WR, H_RD, H_WAIT, H_DONE, CLR
  } state_t;

  state_t state, state_nx;

  logic [AW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fifo_cnt;
  logic [AW-1:0] head;
  logic          fifo_empty, fifo_full;
  logic          push, pop, flush, drop_set;

  logic          clr_pending, clr_go;
  logic          host_pend, add_pend;
  logic          last_grant_host;
  logic [AW-1:0] clr_cnt;
  logic          clr_last;
  logic [DW-1:0] sat_inc;

  logic [AW-1:0] mem_addr_d;
  logic          mem_we_d;
  logic [DW-1:0] mem_wdata_d;
  logic [DW-1:0] rd_data_d;
  logic          rd_valid_d;
  logic          busy_d;

  assign head       = fifo_mem[rd_ptr];
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (PW+1)'(FIFO_DEPTH));

  assign pop      = (state == A_RD);
  assign flush    = (state == IDLE) && (state_nx == CLR);
  assign push     = add_strobe && !busy && !flush && (!fifo_full || pop);
  assign drop_set = add_strobe && !flush && (busy || (fifo_full && !pop));

  assign clr_go   = clear_req || clr_pending;
  // rd_req is still high in the cycle rd_valid is shown; masking it avoids a repeat grant
  assign host_pend = rd_req && !rd_valid;
  assign add_pend  = !fifo_empty;
  assign clr_last  = (clr_cnt == '1);
  assign sat_inc   = (&mem_rdata) ? mem_rdata : mem_rdata + 1'b1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (clr_go)                      state_nx = CLR;
        else if (add_pend && host_pend)  state_nx = last_grant_host ? A_RD : H_RD;
        else if (add_pend)               state_nx = A_RD;
        else if (host_pend)              state_nx = H_RD;
      end
      A_RD:    state_nx = A_WAIT;
      A_WAIT:  state_nx = A_WR;
      A_WR:    state_nx = IDLE;
      H_RD:    state_nx = H_WAIT;
      H_WAIT:  state_nx = H_DONE;
      H_DONE:  state_nx = IDLE;
      CLR:     if (clr_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic: next values for the registered RAM/host outputs
  always_comb begin
    mem_addr_d  = mem_addr;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata;
    rd_data_d   = rd_data;
    rd_valid_d  = 1'b0;
    busy_d      = busy;
    unique case (state)
      IDLE: begin
        if (state_nx == A_RD) begin
          mem_addr_d = head;
        end else if (state_nx == H_RD) begin
          mem_addr_d = rd_addr;
        end else if (state_nx == CLR) begin
          mem_addr_d  = '0;
          mem_we_d    = 1'b1;
          mem_wdata_d = '0;
          busy_d      = 1'b1;
        end
      end
      A_WR: begin
        mem_we_d    = 1'b1;
        mem_wdata_d = sat_inc;
      end
      H_DONE: begin
        rd_data_d  = mem_rdata;
        rd_valid_d = 1'b1;
      end
      CLR: begin
        if (clr_last) begin
          busy_d = 1'b0;
        end else begin
          mem_addr_d  = clr_cnt + 1'b1;
          mem_we_d    = 1'b1;
          mem_wdata_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_addr  <= mem_addr_d;
      mem_we    <= mem_we_d;
      mem_wdata <= mem_wdata_d;
      rd_data   <= rd_data_d;
      rd_valid  <= rd_valid_d;
      busy      <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= add_addr;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_pending     <= 1'b0;
      last_grant_host <= 1'b1;
      drop_flag       <= 1'b0;
      clr_cnt         <= '0;
    end else begin
      clr_pending <= !flush && (clr_pending || clear_req);
      if (flush)         drop_flag <= 1'b0;
      else if (drop_set) drop_flag <= 1'b1;
      if (flush)              clr_cnt <= '0;
      else if (state == CLR)  clr_cnt <= clr_cnt + 1'b1;
      if (state == IDLE && state_nx == A_RD)      last_grant_host <= 1'b0;
      else if (state == IDLE && state_nx == H_RD) last_grant_host <= 1'b1;
    end
  end

endmodule

// File: tb/tb_histogram_ram_scheduler.sv
// Scoreboard bench for histogram_ram_scheduler with a 2-cycle-latency RAM model.
module tb_histogram_ram_scheduler;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          add_strobe = 1'b0;
  logic [AW-1:0] add_addr = '0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          clear_req = 1'b0;
  logic          busy;
  logic          drop_flag;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  histogram_ram_scheduler #(.AW(AW), .DW(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .add_strobe(add_strobe), .add_addr(add_addr),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .clear_req(clear_req), .busy(busy), .drop_flag(drop_flag),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // RAM model: read data appears two cycles after the address is presented
  logic [DW-1:0] ram [256];
  logic [DW-1:0] rd_p1;
  logic          preload_en = 1'b0;
  logic [AW-1:0] preload_addr = '0;
  logic [DW-1:0] preload_data = '0;

  always @(posedge clk) begin
    if (mem_we)          ram[mem_addr] <= mem_wdata;
    else if (preload_en) ram[preload_addr] <= preload_data;
    rd_p1     <= ram[mem_addr];
    mem_rdata <= rd_p1;
  end

  int errors = 0;
  int checks = 0;
  int inc_writes = 0;
  int clr_writes = 0;
  bit loose = 1'b0;
  logic [AW-1:0] wq [$];
  logic [DW-1:0] rq [$];
  logic [DW-1:0] shadow [256];
  logic [AW-1:0] mon_addr;
  logic [DW-1:0] mon_data;

  function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Write monitor: clear writes must carry zero, increment writes must match the queue
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      if (busy) begin
        checks++;
        if (mem_wdata !== '0) begin
          errors++;
          $display("FAIL clear_wdata addr=%h got=%h exp=0000", mem_addr, mem_wdata);
        end
        shadow[mem_addr] = '0;
        clr_writes++;
      end else begin
        mon_addr = mem_addr;
        if (wq.size() > 0) begin
          mon_addr = wq.pop_front();
          checks++;
          if (mem_addr !== mon_addr) begin
            errors++;
            $display("FAIL inc_addr got=%h exp=%h", mem_addr, mon_addr);
          end
        end else if (!loose) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write addr=%h data=%h exp=no write", mem_addr, mem_wdata);
        end
        mon_data = sat_inc(shadow[mon_addr]);
        checks++;
        if (mem_wdata !== mon_data) begin
          errors++;
          $display("FAIL inc_wdata addr=%h got=%h exp=%h", mon_addr, mem_wdata, mon_data);
        end
        shadow[mon_addr] = mon_data;
        inc_writes++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic add(input logic [AW-1:0] a, input bit expect_write);
    add_strobe = 1'b1;
    add_addr   = a;
    if (expect_write) wq.push_back(a);
    tick();
    add_strobe = 1'b0;
  endtask

  task automatic host_read(input logic [AW-1:0] a, input logic [DW-1:0] e, output int lat);
    bit got;
    logic [DW-1:0] exp_v;
    got = 1'b0;
    lat = 0;
    rq.push_back(e);
    rd_req  = 1'b1;
    rd_addr = a;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (rd_valid) got = 1'b1;
      else          lat++;
    end
    exp_v = rq.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rd_timeout addr=%h got=no rd_valid exp=%h", a, exp_v);
    end else if (rd_data !== exp_v) begin
      errors++;
      $display("FAIL rd_data addr=%h got=%h exp=%h", a, rd_data, exp_v);
    end
    tick();
    rd_req = 1'b0;
  endtask

  task automatic wait_busy_rise(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit seen;
    int n;
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (mem_addr !== '0)  begin errors++; $display("FAIL rst_mem_addr got=%h exp=00", mem_addr); end
    checks++; if (mem_we !== 1'b0)  begin errors++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_wdata !== '0) begin errors++; $display("FAIL rst_mem_wdata got=%h exp=0000", mem_wdata); end
    checks++; if (rd_data !== '0)   begin errors++; $display("FAIL rst_rd_data got=%h exp=0000", rd_data); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (drop_flag !== 1'b0) begin errors++; $display("FAIL rst_drop_flag got=%b exp=0", drop_flag); end
    tick();
    rst = 1'b0;
    // Initial sweep gives the RAM model known contents
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wait_busy_rise(seen);
    n = 0;
    while (seen && busy === 1'b1 && n < 300) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 256) begin errors++; $display("FAIL init_clear_len got=%0d exp=256", n); end
    tick();
  endtask

  task automatic test_single_increment();
    bit found;
    int lat;
    int rlat;
    add(8'h80, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mem_addr == 8'h80 && !mem_we) found = 1'b1;
    end
    lat = 0;
    for (int i = 0; i < 10 && found; i++) begin
      @(negedge clk);
      lat++;
      if (mem_we) break;
    end
    checks++;
    if (!found || lat != 3) begin
      errors++;
      $display("FAIL pop_to_write found=%0d got=%0d exp=3", found, lat);
    end
    repeat (4) tick();
    host_read(8'h80, 16'h0001, rlat);
  endtask

  task automatic test_back_to_back();
    int rlat;
    repeat (3) add(8'h81, 1'b1);
    repeat (20) tick();
    host_read(8'h81, 16'h0003, rlat);
    checks++;
    if (drop_flag !== 1'b0) begin errors++; $display("FAIL b2b_drop_flag got=%b exp=0", drop_flag); end
  endtask

  task automatic test_saturation();
    int rlat;
    preload_en   = 1'b1;
    preload_addr = 8'h7F;
    preload_data = 16'hFFFF;
    tick();
    preload_en = 1'b0;
    shadow[8'h7F] = 16'hFFFF;
    add(8'h7F, 1'b1);
    repeat (10) tick();
    host_read(8'h7F, 16'hFFFF, rlat);
  endtask

  task automatic test_fifo_overflow();
    int w0;
    int n;
    int rlat;
    loose = 1'b1;
    w0 = inc_writes;
    repeat (6) add(8'hB0, 1'b0);
    repeat (40) tick();
    loose = 1'b0;
    n = inc_writes - w0;
    checks++;
    if (drop_flag !== 1'b1) begin errors++; $display("FAIL ovf_drop_flag got=%b exp=1", drop_flag); end
    checks++;
    if (n < 1 || n > 5) begin errors++; $display("FAIL ovf_accepted got=%0d exp=1..5", n); end
    host_read(8'hB0, DW'(n), rlat);
  endtask

  task automatic test_arbitration();
    int wa, d1, d2, lat1, lat2, rlat;
    fork
      begin
        repeat (4) add(8'hA0, 1'b1);
      end
      begin
        repeat (2) tick();
        wa = inc_writes;
        host_read(8'h81, 16'h0003, lat1);
        d1 = inc_writes - wa;
        wa = inc_writes;
        host_read(8'h81, 16'h0003, lat2);
        d2 = inc_writes - wa;
      end
    join
    checks++;
    if (lat1 > 8 || lat2 > 8) begin errors++; $display("FAIL arb_latency got=%0d,%0d exp<=8", lat1, lat2); end
    checks++;
    if (d1 != 1) begin errors++; $display("FAIL arb_adds_before_read1 got=%0d exp=1", d1); end
    checks++;
    if (d2 != 1) begin errors++; $display("FAIL arb_adds_between_reads got=%0d exp=1", d2); end
    repeat (30) tick();
    host_read(8'hA0, 16'h0004, rlat);
  endtask

  task automatic test_clear();
    bit found, seen;
    int w0, c0, n, addr_err, nz, rlat;
    w0 = inc_writes;
    c0 = clr_writes;
    add(8'h90, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mem_addr == 8'h90) found = 1'b1;
    end
    tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wait_busy_rise(seen);
    checks++;
    if (!found || !seen || inc_writes - w0 != 1) begin
      errors++;
      $display("FAIL clr_inc_completes found=%0d busy=%0d got=%0d exp=1", found, seen, inc_writes - w0);
    end
    checks++;
    if (drop_flag !== 1'b0) begin errors++; $display("FAIL clr_drop_cleared got=%b exp=0", drop_flag); end
    n = 0;
    addr_err = 0;
    while (seen && busy === 1'b1 && n < 300) begin
      if (mem_addr !== AW'(n)) addr_err++;
      n++;
      @(posedge clk); #1;
      add_strobe = (n == 10);
      add_addr   = 8'h33;
      @(negedge clk);
    end
    add_strobe = 1'b0;
    checks++;
    if (n != 256) begin errors++; $display("FAIL clr_busy_len got=%0d exp=256", n); end
    checks++;
    if (addr_err != 0 || clr_writes - c0 != 256) begin
      errors++;
      $display("FAIL clr_sweep addr_err=%0d writes got=%0d exp=256", addr_err, clr_writes - c0);
    end
    checks++;
    if (drop_flag !== 1'b1) begin errors++; $display("FAIL clr_busy_drop got=%b exp=1", drop_flag); end
    tick();
    nz = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== '0) nz++;
    checks++;
    if (nz != 0) begin errors++; $display("FAIL clr_ram_zero got=%0d nonzero bins exp=0", nz); end
    host_read(8'h80, 16'h0000, rlat);
    host_read(8'h7F, 16'h0000, rlat);
    host_read(8'h90, 16'h0000, rlat);
    checks++;
    if (inc_writes - w0 != 1) begin errors++; $display("FAIL clr_no_late_write got=%0d exp=1", inc_writes - w0); end
  endtask

  initial begin
    test_reset();
    test_single_increment();
    test_back_to_back();
    test_saturation();
    test_fifo_overflow();
    test_arbitration();
    test_clear();
    checks++;
    if (wq.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d exp=0", wq.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
